// File: rtl/ad1_multi_reader.sv
// ad1_multi_reader: parallel serial-ADC reader for AD7476A-class converters.
// Drives one shared SCLK/CS and captures CH_COUNT SDATA lanes per frame.
module ad1_multi_reader #(
    parameter int CH_COUNT     = 2,
    parameter int DATA_WIDTH   = 12,
    parameter int LEAD_ZEROS   = 4,
    parameter int CLK_DIV      = 3,
    parameter int QUIET_CYCLES = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           continuous,
    input  logic [CH_COUNT-1:0]            SDATA,
    output logic                           SCLK,
    output logic                           CS,
    output logic                           busy,
    output logic                           data_valid,
    output logic [CH_COUNT*DATA_WIDTH-1:0] data,
    output logic [CH_COUNT-1:0]            lead_err
);

    localparam int FB   = LEAD_ZEROS + DATA_WIDTH;
    localparam int DIVW = $clog2(CLK_DIV + 1);
    localparam int BITW = $clog2(FB + 1);
    localparam int QW   = $clog2(QUIET_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_QUIET = 2'd2;

    logic [1:0]                     state_q, state_d;
    logic [DIVW-1:0]                div_q, div_d;
    logic [BITW-1:0]                bit_q, bit_d;
    logic [QW-1:0]                  quiet_q, quiet_d;
    logic                           sclk_q, sclk_d;
    logic                           cs_q, cs_d;
    logic                           valid_q, valid_d;
    logic [CH_COUNT*DATA_WIDTH-1:0] data_q, data_d;
    logic [CH_COUNT-1:0]            err_q, err_d;
    logic [FB-1:0]                  sh_q [CH_COUNT];
    logic [FB-1:0]                  sh_d [CH_COUNT];
    logic [FB-1:0]                  sh_nx [CH_COUNT];
    logic [CH_COUNT-1:0]            lead_nx;

    logic div_tc;
    logic rise;
    logic last_bit;
    logic quiet_end;

    assign div_tc    = (div_q == DIVW'(CLK_DIV - 1));
    assign rise      = (state_q == S_CONV) && div_tc && !sclk_q;
    assign last_bit  = rise && (bit_q == BITW'(FB - 1));
    assign quiet_end = (state_q == S_QUIET) &&
                       (quiet_q == QW'(QUIET_CYCLES - 1));

    always_comb begin
        for (int i = 0; i < CH_COUNT; i++) begin
            sh_nx[i] = (sh_q[i] << 1) | FB'(SDATA[i]);
        end
    end

    // Leading bits sit above the result bits once the whole frame is in
    generate
        if (LEAD_ZEROS > 0) begin : g_lead
            for (genvar g = 0; g < CH_COUNT; g++) begin : g_ch
                assign lead_nx[g] = |sh_nx[g][FB-1:DATA_WIDTH];
            end
        end else begin : g_nolead
            assign lead_nx = '0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        quiet_d = quiet_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        valid_d = 1'b0;
        data_d  = data_q;
        err_d   = err_q;
        sh_d    = sh_q;
        case (state_q)
            S_IDLE: begin
                if (start || continuous) begin
                    state_d = S_CONV;
                    cs_d    = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            S_CONV: begin
                if (div_tc) begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                end else begin
                    div_d = div_q + 1'b1;
                end
                if (rise) begin
                    bit_d = bit_q + 1'b1;
                    sh_d  = sh_nx;
                end
                // Final rising edge closes the frame in the same cycle
                if (last_bit) begin
                    state_d = S_QUIET;
                    cs_d    = 1'b1;
                    quiet_d = '0;
                    valid_d = 1'b1;
                    err_d   = lead_nx;
                    for (int i = 0; i < CH_COUNT; i++) begin
                        data_d[i*DATA_WIDTH +: DATA_WIDTH] =
                            sh_nx[i][DATA_WIDTH-1:0];
                    end
                end
            end
            S_QUIET: begin
                if (quiet_end) begin
                    if (continuous) begin
                        state_d = S_CONV;
                        cs_d    = 1'b0;
                        div_d   = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    quiet_d = quiet_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            quiet_q <= '0;
            sclk_q  <= 1'b1;
            cs_q    <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= '0;
            for (int i = 0; i < CH_COUNT; i++) begin
                sh_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            quiet_q <= quiet_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            sh_q    <= sh_d;
        end
    end

    assign SCLK       = sclk_q;
    assign CS         = cs_q;
    assign busy       = (state_q != S_IDLE);
    assign data_valid = valid_q;
    assign data       = data_q;
    assign lead_err   = err_q;

endmodule

// File: tb/tb_ad1_multi_reader.sv
// Scoreboard bench for ad1_multi_reader: ADC models feed frames,
// a monitor checks results, framing and timing against a frame-level model.
module tb_ad1_multi_reader;

    localparam int CH  = 2;
    localparam int DW  = 12;
    localparam int LZ  = 4;
    localparam int CD  = 3;
    localparam int QC  = 5;
    localparam int FB  = LZ + DW;
    localparam int CH2 = 4;
    localparam int DW2 = 8;
    localparam int CD2 = 1;
    localparam int FB2 = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               start, cont;
    logic [CH-1:0]      sdata;
    logic               sclk, cs, busy, dv;
    logic [CH*DW-1:0]   data;
    logic [CH-1:0]      lerr;

    logic               start2, cont2;
    logic [CH2-1:0]     sdata2;
    logic               sclk2, cs2, busy2, dv2;
    logic [CH2*DW2-1:0] data2;
    logic [CH2-1:0]     lerr2;

    ad1_multi_reader #(
        .CH_COUNT(CH), .DATA_WIDTH(DW), .LEAD_ZEROS(LZ),
        .CLK_DIV(CD), .QUIET_CYCLES(QC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(cont),
        .SDATA(sdata), .SCLK(sclk), .CS(cs), .busy(busy),
        .data_valid(dv), .data(data), .lead_err(lerr)
    );

    ad1_multi_reader #(
        .CH_COUNT(CH2), .DATA_WIDTH(DW2), .LEAD_ZEROS(0),
        .CLK_DIV(CD2), .QUIET_CYCLES(QC)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .continuous(cont2),
        .SDATA(sdata2), .SCLK(sclk2), .CS(cs2), .busy(busy2),
        .data_valid(dv2), .data(data2), .lead_err(lerr2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- ADC models + reference model ----------------
    logic [CH*FB-1:0]     fq1 [$];
    logic [CH*DW+CH-1:0]  exp1 [$];
    logic [CH*FB-1:0]     cur1;
    int                   bit1;
    logic [CH2*FB2-1:0]   fq2 [$];
    logic [CH2*DW2+CH2-1:0] exp2 [$];
    logic [CH2*FB2-1:0]   cur2;
    int                   bit2;

    always @(negedge cs) begin
        logic [CH*DW+CH-1:0] e;
        int f;
        cur1 = (fq1.size() > 0) ? fq1.pop_front() : CH*FB'($urandom);
        bit1 = 0;
        e = '0;
        for (int i = 0; i < CH; i++) begin
            f = int'(cur1[i*FB +: FB]);
            e[i*DW +: DW] = DW'(f % (1 << DW));
            e[CH*DW + i]  = (f / (1 << DW)) != 0;
        end
        exp1.push_back(e);
    end

    always @(negedge sclk) begin
        if (!cs && bit1 < FB) begin
            for (int i = 0; i < CH; i++) sdata[i] = cur1[i*FB + FB-1-bit1];
            bit1++;
        end
    end

    always @(negedge cs2) begin
        logic [CH2*DW2+CH2-1:0] e;
        int f;
        cur2 = (fq2.size() > 0) ? fq2.pop_front() : $urandom;
        bit2 = 0;
        e = '0;
        for (int i = 0; i < CH2; i++) begin
            f = int'(cur2[i*FB2 +: FB2]);
            e[i*DW2 +: DW2] = DW2'(f % (1 << DW2));
            e[CH2*DW2 + i]  = (f / (1 << DW2)) != 0;
        end
        exp2.push_back(e);
    end

    always @(negedge sclk2) begin
        if (!cs2 && bit2 < FB2) begin
            for (int i = 0; i < CH2; i++) sdata2[i] = cur2[i*FB2 + FB2-1-bit2];
            bit2++;
        end
    end

    // ---------------- monitors ----------------
    int lo1, hib1, rises1, dvcnt1;
    logic pcs1, psclk1, pbusy1, cs_rise1;
    logic [CH*DW+CH-1:0] e1;

    always @(negedge clk) begin
        if (!rst) begin
            lo1 = 0; hib1 = 0; rises1 = 0;
            pcs1 = 1'b1; psclk1 = 1'b1; pbusy1 = 1'b0;
        end else begin
            cs_rise1 = !pcs1 && cs;
            if (!psclk1 && sclk) rises1++;
            if (dv || cs_rise1) check("dv_with_cs_rise", dv, cs_rise1);
            if (cs_rise1) begin
                check("cs_low_len", lo1, 2*CD*FB);
                check("sclk_rises", rises1, FB);
            end
            if (dv) begin
                dvcnt1++;
                if (exp1.size() == 0) begin
                    check("unexpected_dv", 1, 0);
                end else begin
                    e1 = exp1.pop_front();
                    check("data", data, e1[CH*DW-1:0]);
                    check("lead_err", lerr, e1[CH*DW +: CH]);
                end
            end
            if (pcs1 && !cs) begin
                check("busy_at_cs_fall", busy, 1);
                if (pbusy1) check("quiet_gap", hib1, QC);
                rises1 = 0;
            end
            if (pbusy1 && !busy) check("busy_tail", hib1, QC);
            if (!cs) begin
                lo1  = pcs1 ? 1 : lo1 + 1;
                hib1 = 0;
            end else if (busy) begin
                hib1++;
            end
            pcs1 = cs; psclk1 = sclk; pbusy1 = busy;
        end
    end

    int lo2, dvcnt2;
    logic pcs2;
    logic [CH2*DW2+CH2-1:0] e2;

    always @(negedge clk) begin
        if (!rst) begin
            lo2 = 0; pcs2 = 1'b1;
        end else begin
            if (dv2) begin
                dvcnt2++;
                check("p_cs_low_len", lo2, 2*CD2*FB2);
                if (exp2.size() == 0) begin
                    check("p_unexpected_dv", 1, 0);
                end else begin
                    e2 = exp2.pop_front();
                    check("p_data", data2, e2[CH2*DW2-1:0]);
                    check("p_lead_err", lerr2, e2[CH2*DW2 +: CH2]);
                end
            end
            if (!cs2) lo2 = pcs2 ? 1 : lo2 + 1;
            pcs2 = cs2;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [CH*FB-1:0] rand_frame1();
        logic [CH*FB-1:0] f;
        for (int i = 0; i < CH; i++) begin
            f[i*FB +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
            f[i*FB + DW +: LZ] = ($urandom_range(0, 3) == 0) ?
                LZ'($urandom_range(1, (1 << LZ) - 1)) : '0;
        end
        return f;
    endfunction

    task automatic pulse(input bit second);
        @(negedge clk);
        if (second) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_dv(input int target, input int maxc, input string nm);
        int k = 0;
        while (dvcnt1 < target && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(nm, dvcnt1, target);
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int k = 0;
        while (busy && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(nm, busy, 0);
    endtask

    task automatic shot1(input logic [CH*FB-1:0] f, input string nm);
        int b;
        b = dvcnt1;
        fq1.push_back(f);
        pulse(1'b0);
        wait_dv(b + 1, 200, nm);
        wait_idle(20, "idle_after_shot");
    endtask

    initial begin
        int b, r, k;
        logic ps;
        start = 0; cont = 0; start2 = 0; cont2 = 0;
        sdata = '0; sdata2 = '0;
        dvcnt1 = 0; dvcnt2 = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #20 rst = 1'b1;

        // idle after reset
        repeat (30) @(negedge clk);
        check("rst_sclk", sclk, 1);
        check("rst_cs", cs, 1);
        check("rst_busy", busy, 0);
        check("rst_data", data, 0);
        check("rst_lerr", lerr, 0);
        check("rst_dv", dvcnt1, 0);

        // single shot with known frames
        shot1({16'h0123, 16'h0ABC}, "shot_basic");
        check("t2_data", data, 24'h123ABC);
        check("t2_lerr", lerr, 2'b00);

        // lead-zero violation then a clean frame
        shot1({16'h8FFF, 16'h0555}, "shot_leaderr");
        check("t3_lerr", lerr, 2'b10);
        check("t3_hi", data[23:12], 12'hFFF);
        shot1({16'h0FFF, 16'h0000}, "shot_clean");
        check("t3_clear", lerr, 2'b00);

        // randomized single shots, data must hold between frames
        for (int n = 0; n < 6; n++) begin
            shot1(rand_frame1(), "shot_rand");
            repeat ($urandom_range(1, 20)) @(negedge clk);
            check("hold_dv", dv, 0);
        end

        // continuous mode with ignored start pulses
        for (int n = 0; n < 4; n++) fq1.push_back(rand_frame1());
        b = dvcnt1;
        @(negedge clk);
        cont = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        pulse(1'b0);
        wait_dv(b + 3, 400, "cont_three");
        k = 0;
        while (cs && k < 50) begin @(negedge clk); k++; end
        repeat (40) @(negedge clk);
        pulse(1'b0);
        cont = 1'b0;
        repeat (20) @(negedge clk);
        pulse(1'b0);
        wait_idle(200, "cont_idle");
        check("cont_frames", dvcnt1 - b, 4);
        repeat (150) @(negedge clk);
        check("cont_no_extra", dvcnt1 - b, 4);
        check("cont_still_idle", busy, 0);

        // reset in the middle of a frame
        b = dvcnt1;
        fq1.push_back(rand_frame1());
        pulse(1'b0);
        r = 0; k = 0; ps = sclk;
        while (r < 7 && k < 300) begin
            @(negedge clk);
            if (sclk && !ps) r++;
            ps = sclk;
            k++;
        end
        check("mid_rises", r, 7);
        #2 rst = 1'b0;
        #1;
        check("mid_cs", cs, 1);
        check("mid_sclk", sclk, 1);
        check("mid_busy", busy, 0);
        check("mid_dv", dv, 0);
        check("mid_data", data, 0);
        exp1.delete();
        fq1.delete();
        exp2.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_no_dv", dvcnt1, b);
        check("mid_data_hold", data, 0);
        shot1(rand_frame1(), "after_reset");

        // parameter-swept instance
        for (int n = 0; n < 4; n++) begin
            b = dvcnt2;
            fq2.push_back($urandom);
            pulse(1'b1);
            k = 0;
            while (dvcnt2 == b && k < 100) begin @(negedge clk); k++; end
            check("p_frame", dvcnt2, b + 1);
            repeat (10) @(negedge clk);
            check("p_idle", busy2, 0);
        end

        check("sb_empty1", exp1.size(), 0);
        check("sb_empty2", exp2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ad1_multi_reader.md
Name: ad1_multi_reader

Overview:
- Parametrised serial-ADC reader for Pmod AD1-class converters (AD7476A family); successor to the single-frame AD1 interface.
- Generates its own SCLK from the system clock and drives one shared CS.
- Captures CH_COUNT SDATA lines in parallel, with single-shot and continuous conversion modes and a leading-zero integrity check.
- Sits between the Pmod connector pins and user logic.

Parameters:
- CH_COUNT, 2: number of parallel SDATA lines sharing SCLK/CS (1..8).
- DATA_WIDTH, 12: result bits per channel.
- LEAD_ZEROS, 4: leading bits per frame that must read 0; discarded from the result.
- CLK_DIV, 3: SCLK half-period in clk cycles (>=1).
- QUIET_CYCLES, 5: minimum CS-high time between frames, in clk cycles (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-shot request, sampled in IDLE only
- continuous  in  1  when high, frames run back-to-back
- SDATA  in  CH_COUNT  serial data, bit i = channel i
- SCLK  out  1  serial clock to ADCs, idles high
- CS  out  1  chip select, active low
- busy  out  1  high whenever state is not IDLE
- data_valid  out  1  one-cycle pulse when data updates
- data  out  CH_COUNT*DATA_WIDTH  results; channel i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- lead_err  out  CH_COUNT  per channel: a leading bit read 1 in the last frame

Behaviour:
- FRAME_BITS = LEAD_ZEROS + DATA_WIDTH.
- Reset (rst low), applied immediately and asynchronously:
  - state IDLE; SCLK=1, CS=1.
  - busy=0, data_valid=0, data=0, lead_err=0.
  - all counters and shift registers cleared.
- Reset mid-frame aborts the frame with no data update.
- States: IDLE, CONV, QUIET.
- IDLE:
  - On a clk edge with start=1 or continuous=1: next cycle CS=0, enter CONV, divider=0, bit count=0.
- CONV:
  - Divider counts 0..CLK_DIV-1; at terminal count SCLK toggles and the divider restarts.
  - First SCLK fall occurs CLK_DIV cycles after CS falls.
  - On each cycle where SCLK toggles low->high (rising edge), sample SDATA[i] into per-channel shift register i, MSB first, and increment the bit count.
  - After the FRAME_BITS-th rising edge, on the next clk edge:
    - CS=1, SCLK stays high, enter QUIET.
    - data <= low DATA_WIDTH bits of each shift register.
    - lead_err[i] <= OR of channel i's first LEAD_ZEROS bits.
    - data_valid=1 for exactly that one cycle.
  - CS-low duration = 2*CLK_DIV*FRAME_BITS clk cycles; 96 with defaults.
- QUIET:
  - Hold CS=1, SCLK=1 for QUIET_CYCLES cycles.
  - At the end: if continuous=1, CS=0 next cycle and re-enter CONV directly (no IDLE cycle); otherwise go to IDLE.
- busy is 1 from the cycle CS falls through the last QUIET cycle.
- start asserted while busy is ignored and not queued.
- continuous deasserted mid-frame: the current frame and its QUIET complete, then IDLE.
- start and continuous high together in IDLE: one frame starts; continuous governs chaining.
- data and lead_err hold their values between frames.
- LEAD_ZEROS=0: lead_err is constant 0.
- SDATA is treated as synchronous to the ADC; no synchronisers are inside the block.

Test Plan:
1. Reset then idle: rst low 20 ns, then high, no start -> SCLK=1, CS=1, busy=0, data=0 indefinitely.
2. Single shot (defaults, 100 MHz clk): 1-cycle start pulse; ADC models drive frame 0x0ABC on ch0 and 0x0123 on ch1 on SCLK falls -> CS low exactly 96 cycles, 16 SCLK rising edges, data_valid one cycle at CS rise, data=0x123_ABC, lead_err=00, busy falls 5 cycles after CS rise.
3. Leading-zero violation: ch1 model sends 0x8FFF -> data[23:12]=0xFFF, lead_err=10; a following clean frame clears it to 00.
4. Continuous mode: continuous held high 3 frames, then dropped mid-4th -> CS-high gaps exactly 5 cycles, 4 data_valid pulses, then IDLE; start pulses during busy produce no extra frames.
5. Reset mid-frame: rst low at bit 7 -> CS=1 and SCLK=1 asynchronously, data stays 0, no data_valid; after release, start yields a normal frame.
6. Parameter sweep: CH_COUNT=4, DATA_WIDTH=8, LEAD_ZEROS=0, CLK_DIV=1 -> 16-cycle CS-low window, 4 channels correctly packed, lead_err=0.
